an_encoder_awe_inject_clk: RTL
==============================

Name: an_encoder_awe_inject_clk

Overview:
- Upstream stage feeding the 24-bit AN-code SEC decoder.
- Takes a data word N and produces the AN codeword W = A*N with an iterative shift-and-add multiplier, one multiplier bit per clock.
- Can optionally inject a single arithmetic weight error (±2^k) into W, so the decoder can be exercised and characterised in-system.
- Uses the same A, W_BITS and N_BITS as the decoder, so its W output connects directly to the decoder's W input.

Parameters:
- A, 67, AN-code multiplier constant (odd, nonzero).
- A_BITS, 7, width of A; also the number of multiply iterations.
- N_BITS, 25, data word width.
- W_BITS, 32, codeword width; must satisfy W_BITS >= N_BITS + A_BITS.
- POS_BITS, 5, width of the error-position field (clog2 of W_BITS).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new encode; sampled only in IDLE.
- N_in  in  N_BITS  data word, captured when start is accepted.
- err_en  in  1  inject an AWE into this codeword; captured with start.
- err_sign  in  1  0: add 2^err_pos; 1: subtract 2^err_pos; captured with start.
- err_pos  in  POS_BITS  AWE bit position, 0..W_BITS-1; captured with start.
- busy  out  1  high whenever the state is not IDLE.
- valid  out  1  one-cycle pulse; W is valid from this cycle onward.
- W  out  W_BITS  codeword, held until the next valid pulse.

Behaviour:
- Reset: applies asynchronously on rst_n low. State=IDLE; W=0, valid=0, busy=0; internal acc, idx and captured registers cleared. Reset mid-encode aborts with no valid pulse.
- States: IDLE, CALC, FIN (encode in the shared package).
- IDLE, on a clock edge with start=1:
  - Capture N_in, err_en, err_sign and err_pos.
  - acc<=0, idx<=0; go to CALC.
  - valid<=0 on every IDLE edge.
- CALC, one edge per multiplier bit:
  - acc <= acc + (A[idx] ? (Nreg << idx) : 0), computed in W_BITS-wide arithmetic; idx<=idx+1.
  - When idx==A_BITS-1, go to FIN.
- FIN, one edge:
  - W <= acc, or acc+2^err_pos / acc-2^err_pos when err_en=1 and err_pos<W_BITS.
  - Injection arithmetic is modulo 2^W_BITS, so wrap-around is allowed.
  - err_pos >= W_BITS means no injection.
  - valid<=1; go to IDLE.
- Latency: counting the start-sampling edge as edge 1, W and valid update on edge A_BITS+2 (edge 9 by default). Throughput is one codeword per A_BITS+2 cycles.
- start while busy is ignored and not queued; N_in and err_* changes while busy have no effect.
- A start in the same cycle valid is high is accepted, giving back-to-back operation.
- Overflow cannot occur without injection: max A*N = 67*(2^25-1) = 0x85FFFFBD < 2^32.
- The decoder consumes W on the valid pulse; this block applies no backpressure.

Decomposition:
- Shared package an_code_pkg holds A, A_BITS, N_BITS, W_BITS and POS_BITS, plus the IDLE/CALC/FIN state encoding. The decoder and this block both import it.
- One combinational sub-module, an_awe_inject: inputs word, en, sign, pos; output is the word ± 2^pos mod 2^W_BITS. It is reused by the testbench's reference model.
- The FSM and shift-add datapath stay in the top module.

Test Plan:
- Reset then start with N_in=1, err_en=0 -> valid on edge 9, W=67 (0x43); busy high for edges 1..8.
- N_in=100, err_en=0 -> W=6700. Then N_in=0x1FFFFFF -> W=0x85FFFFBD (max, no overflow).
- N_in=100, err_en=1, sign=0, pos=7 -> W=6828 (6828 mod 67 = 61). N_in=100, sign=1, pos=0 -> W=6699 (residue 66). Decoder downstream returns N=100 in both cases.
- N_in=0, err_en=1, sign=1, pos=0 -> W=0xFFFFFFFF (wrap). Same with pos=31 (0x1F) and sign=0 -> W=0x80000000.
- Pulse start again at edges 3 and 5 with different N_in -> ignored; W reflects the first N_in only. Start on the valid cycle -> next valid exactly 9 edges later.
- Drop rst_n asynchronously during CALC -> W=0, busy=0, valid=0 immediately; no valid pulse appears; the next start encodes correctly.

Source files
------------

// File: rtl/an_encoder_awe_inject_clk_pkg.sv
// Shared AN-code definitions: code constant, widths and encoder state encoding.
// Imported by the encoder, its injector, its bus interface and the decoder.
package an_code_pkg;

    localparam int A        = 67;
    localparam int A_BITS   = 7;
    localparam int N_BITS   = 25;
    localparam int W_BITS   = 32;
    localparam int POS_BITS = 5;

    // Multiplier constant as a bit vector, walked one bit per CALC cycle.
    localparam logic [A_BITS-1:0] A_VEC = A_BITS'(A);

    // Iteration counter width; one spare count so idx+1 never truncates.
    localparam int IDX_BITS = $clog2(A_BITS + 1);
    localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(A_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Single-bit weight 2^pos inside a W_BITS word.
    function automatic logic [W_BITS-1:0] awe_weight(input logic [POS_BITS-1:0] pos);
        awe_weight = {{(W_BITS-1){1'b0}}, 1'b1} << pos;
    endfunction

endpackage

// File: rtl/an_encoder_awe_inject_clk_if.sv
// Encoder request/response bus.
// Handshake: start is a single-cycle request honoured only while busy is low;
// N_in and err_* are sampled on that same edge. There is no ready/backpressure:
// valid is a one-cycle pulse and W stays stable until the next valid pulse.
interface an_encoder_awe_inject_clk_if;
    import an_code_pkg::*;

    logic                start;
    logic [N_BITS-1:0]   N_in;
    logic                err_en;
    logic                err_sign;
    logic [POS_BITS-1:0] err_pos;
    logic                busy;
    logic                valid;
    logic [W_BITS-1:0]   W;

    // Requester side (drives start and the operands).
    modport master (
        output start, N_in, err_en, err_sign, err_pos,
        input  busy, valid, W
    );

    // Encoder side.
    modport slave (
        input  start, N_in, err_en, err_sign, err_pos,
        output busy, valid, W
    );

endinterface

// File: rtl/an_awe_inject.sv
// Arithmetic weight error injector: result = word +/- 2^pos modulo 2^W_BITS.
// Positions at or beyond W_BITS leave the word untouched.
module an_awe_inject
    import an_code_pkg::*;
(
    input  logic [W_BITS-1:0]   word,
    input  logic                en,
    input  logic                sign,
    input  logic [POS_BITS-1:0] pos,
    output logic [W_BITS-1:0]   result
);

    logic [W_BITS-1:0] weight;
    logic              pos_ok;

    // Zero-extend pos by one bit so the range check stays meaningful
    // even when POS_BITS exactly covers W_BITS.
    assign pos_ok = ({1'b0, pos} < (POS_BITS+1)'(W_BITS));
    assign weight = awe_weight(pos);

    // Add or subtract the weight; natural wrap gives the modulo behaviour.
    always_comb begin
        result = word;
        if (en && pos_ok) begin
            if (sign) begin
                result = word - weight;
            end else begin
                result = word + weight;
            end
        end
    end

endmodule

// File: rtl/an_encoder_awe_inject_clk.sv
// AN-code encoder: W = A*N by serial shift-and-add (one multiplier bit per
// clock), with optional single arithmetic-weight-error injection on output.
// Latency from the start-sampling edge to valid is A_BITS+2 edges.
module an_encoder_awe_inject_clk
    import an_code_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    an_encoder_awe_inject_clk_if.slave   bus,
    output state_t                       state_dbg
);

    state_t              state;
    state_t              state_nxt;

    logic [N_BITS-1:0]   n_reg;
    logic                err_en_r;
    logic                err_sign_r;
    logic [POS_BITS-1:0] err_pos_r;
    logic [W_BITS-1:0]   acc;
    logic [IDX_BITS-1:0] idx;
    logic [W_BITS-1:0]   w_r;
    logic                valid_r;

    logic [W_BITS-1:0]   addend;
    logic [W_BITS-1:0]   w_inj;

    assign bus.busy   = (state != ST_IDLE);
    assign bus.valid  = valid_r;
    assign bus.W      = w_r;
    assign state_dbg  = state;

    // Partial product for the current multiplier bit, in full codeword width.
    assign addend = A_VEC[idx] ? (W_BITS'(n_reg) << idx) : '0;

    // Final codeword with the captured error (if any) applied.
    an_awe_inject u_inject (
        .word   (acc),
        .en     (err_en_r),
        .sign   (err_sign_r),
        .pos    (err_pos_r),
        .result (w_inj)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> CALC on start, A_BITS CALC cycles, one FIN cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_CALC;
            ST_CALC: if (idx == IDX_LAST) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add accumulation, output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg      <= '0;
            err_en_r   <= 1'b0;
            err_sign_r <= 1'b0;
            err_pos_r  <= '0;
            acc        <= '0;
            idx        <= '0;
            w_r        <= '0;
            valid_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        n_reg      <= bus.N_in;
                        err_en_r   <= bus.err_en;
                        err_sign_r <= bus.err_sign;
                        err_pos_r  <= bus.err_pos;
                        acc        <= '0;
                        idx        <= '0;
                    end
                end
                ST_CALC: begin
                    acc <= acc + addend;
                    idx <= idx + 1'b1;
                end
                ST_FIN: begin
                    w_r     <= w_inj;
                    valid_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
